// File: rtl/decode_stage.sv
// decode_stage: registered, handshaked instruction decode with branch resolution and load-use stalls
module decode_stage #(
  parameter int DATA_WIDTH       = 16,
  parameter int REG_ADDR_WIDTH   = 3,
  parameter int PC_REG           = 6,
  parameter int LOAD_USE_BUBBLES = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [15:0]               instr,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic [2:0]                cond_bits,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [REG_ADDR_WIDTH-1:0] destination_reg,
  output logic [REG_ADDR_WIDTH-1:0] first_reg,
  output logic [REG_ADDR_WIDTH-1:0] second_reg,
  output logic [DATA_WIDTH-1:0]     offset,
  output logic [2:0]                alu_op,
  output logic                      ram_read,
  output logic                      ram_write,
  output logic                      branch_taken
);
  localparam int RW = REG_ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  logic          is_br;
  logic          is_ls;
  logic          is_rr;
  logic          is_ai;
  logic          taken;
  logic [RW-1:0] d_dest;
  logic [RW-1:0] d_first;
  logic [RW-1:0] d_second;
  logic [DW-1:0] d_off;
  logic [2:0]    d_op;
  logic          d_rd;
  logic          d_wr;
  logic          d_bt;
  logic [1:0]    haz_cnt;
  logic [RW-1:0] haz_reg;
  logic          stall;
  logic          accept;
  // decode the incoming word; shift and ALU-immediate share field positions so they share the fallthrough
  always_comb begin
    is_br    = instr[15];
    is_ls    = instr[15:14] == 2'b01;
    is_rr    = instr[15:11] == 5'b00001;
    is_ai    = instr[15:13] == 3'b001;
    taken    = instr[14:12] == 3'b000 ? 1'b1 :
               instr[14:12] == 3'b001 ? cond_bits[0] :
               instr[14:12] == 3'b010 ? cond_bits[1] :
               instr[14:12] == 3'b100 ? cond_bits[2] :
               instr[14:12] == 3'b101 ? cond_bits[0] | cond_bits[2] :
               instr[14:12] == 3'b110 ? cond_bits[1] | cond_bits[2] : 1'b0;
    d_bt     = is_br && taken;
    d_dest   = is_br ? RW'(PC_REG) : is_ls ? RW'(instr[12:10]) : is_rr ? RW'(instr[8:6]) : RW'(instr[10:8]);
    d_first  = is_br ? RW'(PC_REG) : is_ls ? RW'(instr[9:7]) : is_rr ? RW'(instr[5:3]) : RW'(instr[7:5]);
    d_second = is_rr ? RW'(instr[2:0]) : '0;
    d_off    = is_br ? (taken ? {{(DW-12){instr[11]}}, instr[11:0]} : DW'(1)) :
               is_ls ? {{(DW-7){instr[6]}}, instr[6:0]} :
               is_rr ? '0 : {{(DW-5){instr[4]}}, instr[4:0]};
    d_op     = (is_br || is_ls) ? 3'b100 : is_rr ? {1'b1, instr[10:9]} : is_ai ? {1'b1, instr[12:11]} : 3'b000;
    d_rd     = is_ls && !instr[13];
    d_wr     = is_ls && instr[13];
  end
  // stall a consumer of a recently handed-off load; stores also read their data register
  always_comb begin
    stall       = haz_cnt != 2'd0 && instr_valid && haz_reg != '0 &&
                  (d_first == haz_reg || d_second == haz_reg || (d_wr && d_dest == haz_reg));
    instr_ready = !flush && !stall && (!out_valid || out_ready);
    accept      = instr_valid && instr_ready;
  end
  // output valid: flush wins, then a new accept, then a downstream handoff empties the stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) out_valid <= 1'b0;
    else       out_valid <= flush ? 1'b0 : accept ? 1'b1 : out_ready ? 1'b0 : out_valid;
  end
  // decoded fields load on accept and otherwise hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      destination_reg <= '0;
      first_reg       <= '0;
      second_reg      <= '0;
      offset          <= '0;
      alu_op          <= 3'b100;
      ram_read        <= 1'b0;
      ram_write       <= 1'b0;
      branch_taken    <= 1'b0;
    end else if (accept) begin
      destination_reg <= d_dest;
      first_reg       <= d_first;
      second_reg      <= d_second;
      offset          <= d_off;
      alu_op          <= d_op;
      ram_read        <= d_rd;
      ram_write       <= d_wr;
      branch_taken    <= d_bt;
    end
  end
  // countdown scoreboard armed when a load leaves the stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      haz_cnt <= 2'd0;
      haz_reg <= '0;
    end else if (flush) begin
      haz_cnt <= 2'd0;
    end else if (out_valid && out_ready && ram_read) begin
      haz_cnt <= 2'(LOAD_USE_BUBBLES);
      haz_reg <= destination_reg;
    end else if (haz_cnt != 2'd0) begin
      haz_cnt <= haz_cnt - 2'd1;
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scoreboard bench for decode_stage (default build plus a 32-bit no-stall build)
module tb_decode_stage;
  typedef struct packed {
    logic [2:0]  dest;
    logic [2:0]  first;
    logic [2:0]  second;
    logic [15:0] off;
    logic [2:0]  op;
    logic        rd;
    logic        wr;
    logic        bt;
  } exp_t;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        instr_valid;
  logic [2:0]  cond_bits;
  logic        flush;
  logic        out_ready;
  logic        instr_ready;
  logic        out_valid;
  logic [2:0]  destination_reg;
  logic [2:0]  first_reg;
  logic [2:0]  second_reg;
  logic [15:0] offset;
  logic [2:0]  alu_op;
  logic        ram_read;
  logic        ram_write;
  logic        branch_taken;
  logic        ready_w;
  logic        valid_w;
  logic [2:0]  dest_w;
  logic [2:0]  first_w;
  logic [2:0]  second_w;
  logic [31:0] offset_w;
  logic [2:0]  op_w;
  logic        rd_w;
  logic        wr_w;
  logic        bt_w;
  exp_t        q[$];
  int          passed = 0;
  int          failed = 0;
  int          total  = 0;
  int          w;
  decode_stage dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .cond_bits(cond_bits), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .destination_reg(destination_reg), .first_reg(first_reg), .second_reg(second_reg),
    .offset(offset), .alu_op(alu_op), .ram_read(ram_read), .ram_write(ram_write),
    .branch_taken(branch_taken)
  );
  decode_stage #(.DATA_WIDTH(32), .LOAD_USE_BUBBLES(0)) dut_w (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid), .instr_ready(ready_w),
    .cond_bits(cond_bits), .flush(flush), .out_valid(valid_w), .out_ready(out_ready),
    .destination_reg(dest_w), .first_reg(first_w), .second_reg(second_w),
    .offset(offset_w), .alu_op(op_w), .ram_read(rd_w), .ram_write(wr_w),
    .branch_taken(bt_w)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin passed++; end
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic exp_t mk(input logic [2:0] d, input logic [2:0] f, input logic [2:0] s,
                              input logic [15:0] o, input logic [2:0] op,
                              input logic rd, input logic wr, input logic bt);
    mk = {d, f, s, o, op, rd, wr, bt};
  endfunction
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("sb_unexpected_out", 64'(out_valid), 64'd0);
      else begin
        e = q.pop_front();
        chk("sb_dest", 64'(destination_reg), 64'(e.dest));
        chk("sb_first", 64'(first_reg), 64'(e.first));
        chk("sb_second", 64'(second_reg), 64'(e.second));
        chk("sb_offset", 64'(offset), 64'(e.off));
        chk("sb_alu_op", 64'(alu_op), 64'(e.op));
        chk("sb_ram_read", 64'(ram_read), 64'(e.rd));
        chk("sb_ram_write", 64'(ram_write), 64'(e.wr));
        chk("sb_branch_taken", 64'(branch_taken), 64'(e.bt));
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [15:0] i, input logic [2:0] c, input exp_t e, output int n);
    instr = i;
    cond_bits = c;
    instr_valid = 1'b1;
    #1;
    n = 0;
    while (!instr_ready && n < 20) begin
      step();
      n++;
    end
    chk("send_accept", 64'(instr_ready), 64'd1);
    q.push_back(e);
    step();
  endtask
  initial begin
    reset = 1'b1;
    instr = '0;
    instr_valid = 1'b0;
    cond_bits = '0;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_alu_op", 64'(alu_op), 64'd4);
    chk("rst_offset", 64'(offset), 64'd0);
    chk("rst_dest", 64'(destination_reg), 64'd0);
    chk("rst_branch", 64'(branch_taken), 64'd0);
    reset = 1'b0;
    #1;
    chk("rst_ready", 64'(instr_ready), 64'd1);
    send(16'h2A25, 3'b000, mk(3'd2, 3'd1, 3'd0, 16'h0005, 3'b101, 1'b0, 1'b0, 1'b0), w);
    chk("b2b_first_wait", 64'(w), 64'd0);
    send(16'h0A53, 3'b000, mk(3'd1, 3'd2, 3'd3, 16'h0000, 3'b101, 1'b0, 1'b0, 1'b0), w);
    chk("b2b_second_wait", 64'(w), 64'd0);
    chk("b2b_valid", 64'(out_valid), 64'd1);
    send(16'h9FFE, 3'b001, mk(3'd6, 3'd6, 3'd0, 16'hFFFE, 3'b100, 1'b0, 1'b0, 1'b1), w);
    chk("w32_taken_offset", 64'(offset_w), 64'hFFFF_FFFE);
    send(16'h9FFE, 3'b010, mk(3'd6, 3'd6, 3'd0, 16'h0001, 3'b100, 1'b0, 1'b0, 1'b0), w);
    chk("w32_not_taken_offset", 64'(offset_w), 64'd1);
    send(16'h8005, 3'b000, mk(3'd6, 3'd6, 3'd0, 16'h0005, 3'b100, 1'b0, 1'b0, 1'b1), w);
    send(16'hF000, 3'b111, mk(3'd6, 3'd6, 3'd0, 16'h0001, 3'b100, 1'b0, 1'b0, 1'b0), w);
    send(16'hC7FF, 3'b100, mk(3'd6, 3'd6, 3'd0, 16'h07FF, 3'b100, 1'b0, 1'b0, 1'b1), w);
    send(16'h0571, 3'b000, mk(3'd5, 3'd3, 3'd0, 16'hFFF1, 3'b000, 1'b0, 1'b0, 1'b0), w);
    send(16'h6C7F, 3'b000, mk(3'd3, 3'd0, 3'd0, 16'hFFFF, 3'b100, 1'b0, 1'b1, 1'b0), w);
    instr_valid = 1'b0;
    step();
    send(16'h4480, 3'b000, mk(3'd1, 3'd1, 3'd0, 16'h0000, 3'b100, 1'b1, 1'b0, 1'b0), w);
    instr_valid = 1'b0;
    step();
    instr = 16'h0A48;
    instr_valid = 1'b1;
    #1;
    chk("lu_ready", 64'(instr_ready), 64'd0);
    chk("lu_nobubble_ready", 64'(ready_w), 64'd1);
    send(16'h0A48, 3'b000, mk(3'd1, 3'd1, 3'd0, 16'h0000, 3'b101, 1'b0, 1'b0, 1'b0), w);
    chk("lu_stall_cycles", 64'(w), 64'd1);
    instr_valid = 1'b0;
    step();
    send(16'h4480, 3'b000, mk(3'd1, 3'd1, 3'd0, 16'h0000, 3'b100, 1'b1, 1'b0, 1'b0), w);
    send(16'h0A48, 3'b000, mk(3'd1, 3'd1, 3'd0, 16'h0000, 3'b101, 1'b0, 1'b0, 1'b0), w);
    chk("handoff_no_stall", 64'(w), 64'd0);
    instr_valid = 1'b0;
    step();
    step();
    out_ready = 1'b0;
    send(16'h2A25, 3'b000, mk(3'd2, 3'd1, 3'd0, 16'h0005, 3'b101, 1'b0, 1'b0, 1'b0), w);
    instr = 16'h0571;
    instr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready", 64'(instr_ready), 64'd0);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_dest", 64'(destination_reg), 64'd2);
      chk("bp_offset", 64'(offset), 64'd5);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(instr_ready), 64'd1);
    send(16'h0571, 3'b000, mk(3'd5, 3'd3, 3'd0, 16'hFFF1, 3'b000, 1'b0, 1'b0, 1'b0), w);
    chk("bp_release_wait", 64'(w), 64'd0);
    instr_valid = 1'b0;
    step();
    send(16'h4480, 3'b000, mk(3'd1, 3'd1, 3'd0, 16'h0000, 3'b100, 1'b1, 1'b0, 1'b0), w);
    send(16'h2A25, 3'b000, mk(3'd2, 3'd1, 3'd0, 16'h0005, 3'b101, 1'b0, 1'b0, 1'b0), w);
    out_ready = 1'b0;
    flush = 1'b1;
    instr = 16'h0A48;
    #1;
    chk("flush_ready", 64'(instr_ready), 64'd0);
    q.delete();
    step();
    flush = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_no_stall", 64'(instr_ready), 64'd1);
    send(16'h0A48, 3'b000, mk(3'd1, 3'd1, 3'd0, 16'h0000, 3'b101, 1'b0, 1'b0, 1'b0), w);
    chk("flush_dep_wait", 64'(w), 64'd0);
    instr_valid = 1'b0;
    step();
    out_ready = 1'b0;
    send(16'h9FFE, 3'b001, mk(3'd6, 3'd6, 3'd0, 16'hFFFE, 3'b100, 1'b0, 1'b0, 1'b1), w);
    instr_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_alu_op", 64'(alu_op), 64'd4);
    chk("arst_dest", 64'(destination_reg), 64'd0);
    chk("arst_offset", 64'(offset), 64'd0);
    chk("arst_branch", 64'(branch_taken), 64'd0);
    chk("arst_w32_valid", 64'(valid_w), 64'd0);
    q.delete();
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("arst_ready", 64'(instr_ready), 64'd1);
    chk("arst_valid_after", 64'(out_valid), 64'd0);
    step();
    chk("sb_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
